// File: rtl/scan_hex.sv
// rtl/scan_hex.sv - UART-side scanner returning a raw byte or a parsed hex word over req/ack
module scan_hex #(
    parameter int DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rx,
    input  logic        type_rx,
    output logic        ack_rx,
    output logic [31:0] din_rx,
    output logic        err_rx,
    input  logic [7:0]  d_rx,
    input  logic        vld_rx,
    output logic        rdy_rx
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        DECODE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      char_q, char_nxt;
    logic [31:0]     din_nxt;
    logic            err_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic            type_q, type_nxt;

    logic            is_hex;
    logic            is_term;
    logic [3:0]      nibble;

    // Handshake outputs come straight from the state register.
    assign rdy_rx = (state == RECV);
    assign ack_rx = (state == DONE);

    // Character classification of the latched byte.
    always_comb begin
        is_hex  = 1'b0;
        is_term = 1'b0;
        nibble  = 4'h0;
        if (char_q >= 8'h30 && char_q <= 8'h39) begin
            is_hex = 1'b1;
            nibble = char_q[3:0];
        end else if ((char_q >= 8'h41 && char_q <= 8'h46) ||
                     (char_q >= 8'h61 && char_q <= 8'h66)) begin
            is_hex = 1'b1;
            nibble = 4'(char_q[3:0] + 4'd9);
        end else if (char_q == 8'h20 || char_q == 8'h0D) begin
            is_term = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            char_q <= 8'h00;
            din_rx <= 32'h0;
            err_rx <= 1'b0;
            count  <= '0;
            type_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            char_q <= char_nxt;
            din_rx <= din_nxt;
            err_rx <= err_nxt;
            count  <= count_nxt;
            type_q <= type_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        char_nxt  = char_q;
        din_nxt   = din_rx;
        err_nxt   = err_rx;
        count_nxt = count;
        type_nxt  = type_q;
        case (state)
            IDLE: begin
                if (req_rx) begin
                    type_nxt  = type_rx;
                    din_nxt   = 32'h0;
                    err_nxt   = 1'b0;
                    count_nxt = '0;
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (vld_rx) begin
                    char_nxt  = d_rx;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (!type_q) begin
                    din_nxt   = {24'h0, char_q};
                    state_nxt = DONE;
                end else if (is_hex) begin
                    if (count < MAX_CNT) begin
                        din_nxt   = {din_rx[27:0], nibble};
                        count_nxt = count + 1'b1;
                        state_nxt = RECV;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (is_term) begin
                    // Whitespace before the first digit is skipped.
                    state_nxt = (count == '0) ? RECV : DONE;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!req_rx) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_scan_hex.sv
// tb/tb_scan_hex.sv - scoreboard bench for scan_hex with directed byte and hex-word tokens
module tb_scan_hex;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rx;
    logic        type_rx;
    logic        ack_rx;
    logic [31:0] din_rx;
    logic        err_rx;
    logic [7:0]  d_rx;
    logic        vld_rx;
    logic        rdy_rx;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    scan_hex #(.DIGITS(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_rx  (req_rx),
        .type_rx (type_rx),
        .ack_rx  (ack_rx),
        .din_rx  (din_rx),
        .err_rx  (err_rx),
        .d_rx    (d_rx),
        .vld_rx  (vld_rx),
        .rdy_rx  (rdy_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation on each rising ack_rx.
    initial begin
        logic ack_prev;
        logic [32:0] e;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_rx === 1'b1 && ack_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_ack: got ack with din %h, expected no result", din_rx);
                end else begin
                    e = exp_q.pop_front();
                    check("result_din", din_rx, e[31:0]);
                    check("result_err", {31'h0, err_rx}, {31'h0, e[32]});
                end
            end
            ack_prev = ack_rx;
        end
    end

    task automatic start_scan(input logic t, input logic push, input logic [31:0] edin, input logic eerr);
        @(negedge clk);
        req_rx  = 1'b1;
        type_rx = t;
        if (push) exp_q.push_back({eerr, edin});
        @(negedge clk);
        type_rx = ~t;
        check("rdy_after_req", {31'h0, rdy_rx}, 32'h1);
    endtask

    task automatic send_char(input logic [7:0] c, input logic more);
        int w;
        d_rx   = c;
        vld_rx = 1'b1;
        w = 0;
        while (rdy_rx !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w == 20) check("rdy_timeout", {31'h0, rdy_rx}, 32'h1);
        @(negedge clk);
        vld_rx = 1'b0;
        check("rdy_low_after_xfer", {31'h0, rdy_rx}, 32'h0);
        if (more) begin
            @(negedge clk);
            check("rdy_back_high", {31'h0, rdy_rx}, 32'h1);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_char(s[i], (i != s.len() - 1));
    endtask

    task automatic finish_scan();
        int w;
        w = 0;
        while (ack_rx !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w == 20) check("ack_timeout", {31'h0, ack_rx}, 32'h1);
        check("no_rdy_in_done", {31'h0, rdy_rx}, 32'h0);
        @(negedge clk);
        check("ack_held_while_req", {31'h0, ack_rx}, 32'h1);
        req_rx = 1'b0;
        @(negedge clk);
        check("ack_drop_after_req", {31'h0, ack_rx}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic stall_bad;
        rst = 1'b1; req_rx = 1'b0; type_rx = 1'b0; d_rx = 8'h00; vld_rx = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ack", {31'h0, ack_rx}, 32'h0);
        check("reset_rdy", {31'h0, rdy_rx}, 32'h0);
        check("reset_err", {31'h0, err_rx}, 32'h0);
        check("reset_din", din_rx, 32'h0);

        // Byte mode: ack two cycles after the transfer edge.
        start_scan(1'b0, 1'b1, 32'h0000_0041, 1'b0);
        send_char(8'h41, 1'b0);
        check("byte_ack_not_yet", {31'h0, ack_rx}, 32'h0);
        @(negedge clk);
        check("byte_ack_latency", {31'h0, ack_rx}, 32'h1);
        finish_scan();

        start_scan(1'b1, 1'b1, 32'h0000_1A2B, 1'b0);
        send_str("1a2B\r");
        finish_scan();

        start_scan(1'b1, 1'b1, 32'h0000_00FF, 1'b0);
        send_str("  FF ");
        finish_scan();

        start_scan(1'b1, 1'b1, 32'h0000_0012, 1'b1);
        send_str("12G");
        d_rx = 8'h33; vld_rx = 1'b1;
        finish_scan();
        check("no_consume_idle", {31'h0, rdy_rx}, 32'h0);
        vld_rx = 1'b0;

        start_scan(1'b1, 1'b1, 32'h1234_5678, 1'b1);
        send_str("123456789");
        finish_scan();

        start_scan(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        send_str("DEADBEEF\r");
        finish_scan();

        // Reset in the middle of a token abandons it.
        start_scan(1'b1, 1'b0, 32'h0, 1'b0);
        send_char("A", 1'b1);
        send_char("B", 1'b1);
        req_rx = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ack", {31'h0, ack_rx}, 32'h0);
        check("midrst_rdy", {31'h0, rdy_rx}, 32'h0);
        check("midrst_err", {31'h0, err_rx}, 32'h0);
        check("midrst_din", din_rx, 32'h0);

        start_scan(1'b1, 1'b1, 32'h0000_0007, 1'b0);
        send_char("7", 1'b1);
        stall_bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (ack_rx !== 1'b0 || rdy_rx !== 1'b1) stall_bad = 1'b1;
        end
        check("stall_no_progress", {31'h0, stall_bad}, 32'h0);
        send_char(8'h0D, 1'b0);
        finish_scan();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
